// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display reader: segment patterns,
// special codes and the capture FSM state type.
package seg7_pkg;

    // Active-low patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] PAD_0     = 7'b1000000;
    localparam logic [6:0] PAD_1     = 7'b1111001;
    localparam logic [6:0] PAD_2     = 7'b0100100;
    localparam logic [6:0] PAD_3     = 7'b0110000;
    localparam logic [6:0] PAD_4     = 7'b0011001;
    localparam logic [6:0] PAD_5     = 7'b0010010;
    localparam logic [6:0] PAD_6     = 7'b0000010;
    localparam logic [6:0] PAD_7     = 7'b1111000;
    localparam logic [6:0] PAD_8     = 7'b0000000;
    localparam logic [6:0] PAD_9     = 7'b0011000;
    localparam logic [6:0] PAD_TRACO = 7'b0111111;

    localparam logic [4:0] COD_TRACO = 5'd31;
    localparam logic [4:0] COD_INVAL = 5'd30;

    typedef enum logic [1:0] {
        OCIOSO,
        FILTRANDO,
        CAPTURADO
    } estado_t;

endpackage

// File: rtl/seg7_decod.sv
// Combinational lookup from an active-low segment pattern to a digit code.
module seg7_decod
    import seg7_pkg::*;
(
    input  logic [6:0] padrao,
    output logic [4:0] codigo
);

    always_comb begin
        case (padrao)
            PAD_0:     codigo = 5'd0;
            PAD_1:     codigo = 5'd1;
            PAD_2:     codigo = 5'd2;
            PAD_3:     codigo = 5'd3;
            PAD_4:     codigo = 5'd4;
            PAD_5:     codigo = 5'd5;
            PAD_6:     codigo = 5'd6;
            PAD_7:     codigo = 5'd7;
            PAD_8:     codigo = 5'd8;
            PAD_9:     codigo = 5'd9;
            PAD_TRACO: codigo = COD_TRACO;
            default:   codigo = COD_INVAL;
        endcase
    end

endmodule

// File: rtl/seg7_leitor.sv
// Reads a multiplexed seven-segment display bus, debounces each position and
// emits complete decoded frames. Define SEG7_LEITOR_CONTERRO_EN for the nerros counter.
module seg7_leitor
    import seg7_pkg::*;
#(
    parameter int ESTAVEL = 4,
    parameter int NDIG    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        segmentos,
    input  logic [NDIG-1:0]   anodos,
    output logic [5*NDIG-1:0] digitos,
    output logic              valido,
`ifdef SEG7_LEITOR_CONTERRO_EN
    output logic [7:0]        nerros,
`endif
    output logic              erro
);

    localparam int         IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [3:0] EST4 = 4'(ESTAVEL);

    logic [6:0]      seg_r, cmp_seg;
    logic [NDIG-1:0] an_r, cmp_an;
    logic [NDIG-1:0] mask, mask_prox;
    logic [3:0]      cont;
    logic [4:0]      shadow [NDIG];
    logic [4:0]      codigo;
    logic [IW-1:0]   pos_cmp;
    estado_t         estado, estado_prox;
    logic            uma_ativa, igual, estavel_prox;
    logic            carrega, incrementa, captura;

    seg7_decod u_decod (
        .padrao (cmp_seg),
        .codigo (codigo)
    );

    assign uma_ativa    = ($countones(~an_r) == 1);
    assign igual        = (an_r == cmp_an) && (seg_r == cmp_seg);
    assign estavel_prox = ((cont + 4'd1) == EST4);

    always_comb begin
        pos_cmp = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (!cmp_an[i]) pos_cmp = IW'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:    if (uma_ativa) estado_prox = FILTRANDO;
            FILTRANDO: begin
                if (igual)          estado_prox = estavel_prox ? CAPTURADO : FILTRANDO;
                else if (uma_ativa) estado_prox = FILTRANDO;
                else                estado_prox = OCIOSO;
            end
            CAPTURADO: begin
                if (an_r != cmp_an) estado_prox = uma_ativa ? FILTRANDO : OCIOSO;
            end
            default:   estado_prox = OCIOSO;
        endcase
    end

    always_comb begin
        carrega    = 1'b0;
        incrementa = 1'b0;
        captura    = 1'b0;
        case (estado)
            OCIOSO:    carrega = uma_ativa;
            FILTRANDO: begin
                if (igual) begin
                    captura    = estavel_prox;
                    incrementa = !estavel_prox;
                end else begin
                    carrega = uma_ativa;
                end
            end
            CAPTURADO: carrega = (an_r != cmp_an) && uma_ativa;
            default:   ;
        endcase
    end

    // A capture landing on the commit edge starts the next frame's mask.
    always_comb begin
        mask_prox = (&mask) ? '0 : mask;
        if (captura) mask_prox[pos_cmp] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_r   <= '1;
            an_r    <= '1;
            cmp_seg <= '1;
            cmp_an  <= '1;
            cont    <= '0;
            mask    <= '0;
            valido  <= 1'b0;
            erro    <= 1'b0;
            for (int unsigned i = 0; i < NDIG; i++) begin
                shadow[i]          <= COD_TRACO;
                digitos[5*i +: 5]  <= COD_TRACO;
            end
        end else begin
            seg_r  <= segmentos;
            an_r   <= anodos;
            mask   <= mask_prox;
            valido <= 1'b0;

            if (carrega) begin
                cmp_seg <= seg_r;
                cmp_an  <= an_r;
                cont    <= 4'd1;
            end else if (incrementa) begin
                cont <= cont + 4'd1;
            end else if (captura) begin
                cont <= EST4;
            end else if (estado_prox == OCIOSO) begin
                cont <= '0;
            end

            if (captura) begin
                shadow[pos_cmp] <= codigo;
                if (codigo == COD_INVAL) erro <= 1'b1;
            end

            if (&mask) begin
                valido <= 1'b1;
                for (int unsigned i = 0; i < NDIG; i++) digitos[5*i +: 5] <= shadow[i];
            end
        end
    end

`ifdef SEG7_LEITOR_CONTERRO_EN
    always_ff @(posedge clock) begin
        if (reset)
            nerros <= '0;
        else if (captura && (codigo == COD_INVAL) && (nerros != 8'hFF))
            nerros <= nerros + 8'd1;
    end
`endif

endmodule

// File: tb/tb_seg7_leitor.sv
// Randomized and directed bench for seg7_leitor against a run-length reference model.
module tb_seg7_leitor;

    localparam int ESTAVEL = 4;
    localparam int NDIG    = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [6:0]        segmentos = '1;
    logic [NDIG-1:0]   anodos = '1;
    logic [5*NDIG-1:0] digitos;
    logic              valido;
    logic              erro;
`ifdef SEG7_LEITOR_CONTERRO_EN
    logic [7:0]        nerros;
`endif

    seg7_leitor #(.ESTAVEL(ESTAVEL), .NDIG(NDIG)) dut (
        .clock     (clock),
        .reset     (reset),
        .segmentos (segmentos),
        .anodos    (anodos),
        .digitos   (digitos),
        .valido    (valido),
`ifdef SEG7_LEITOR_CONTERRO_EN
        .nerros    (nerros),
`endif
        .erro      (erro)
    );

    always #5 clock = ~clock;

    int ncomp = 0;
    int nfalha = 0;
    int npulsos = 0;

    task automatic confere(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        ncomp++;
        if (obs !== esp) begin
            nfalha++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    logic [6:0] tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    function automatic int ref_cod(input logic [6:0] p);
        if (p == 7'b0111111) return 31;
        for (int d = 0; d < 10; d++) if (tab[d] == p) return d;
        return 30;
    endfunction

    // Model: a capture fires when ESTAVEL consecutive identical one-hot samples
    // are seen; after a capture the position stays locked until anodos changes.
    int              m_sh [NDIG];
    int              m_dig [NDIG];
    bit              m_mask [NDIG];
    bit              m_val, m_erro, m_pend, m_trav;
    int              m_run, m_nerr;
    logic [NDIG-1:0] m_tan, m_lan, p_an;
    logic [6:0]      m_lseg, p_seg;

    task automatic modelo_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_sh[i] = 31; m_dig[i] = 31; m_mask[i] = 0;
        end
        m_val = 0; m_erro = 0; m_pend = 0; m_trav = 0; m_run = 0; m_nerr = 0;
        m_tan = '1; m_lan = '1; m_lseg = '1; p_an = '1; p_seg = '1;
    endtask

    task automatic modelo_borda(input logic [NDIG-1:0] an, input logic [6:0] seg);
        bit onehot;
        bit cheio;
        int pos;
        int cod;
        m_val = 0;
        if (m_pend) begin
            for (int i = 0; i < NDIG; i++) begin
                m_dig[i] = m_sh[i]; m_mask[i] = 0;
            end
            m_val = 1; m_pend = 0;
        end
        onehot = ($countones(~an) == 1);
        if (m_trav) begin
            if (an != m_tan) begin
                m_trav = 0;
                m_run  = onehot ? 1 : 0;
            end
        end else if (!onehot) m_run = 0;
        else if (m_run > 0 && an == m_lan && seg == m_lseg) m_run++;
        else m_run = 1;
        if (!m_trav && m_run == ESTAVEL) begin
            pos = 0;
            for (int i = 0; i < NDIG; i++) if (!an[i]) pos = i;
            cod = ref_cod(seg);
            m_sh[pos] = cod; m_mask[pos] = 1;
            m_trav = 1; m_tan = an;
            if (cod == 30) begin
                m_erro = 1;
                if (m_nerr < 255) m_nerr++;
            end
        end
        m_lan = an; m_lseg = seg;
        cheio = 1;
        for (int i = 0; i < NDIG; i++) cheio &= m_mask[i];
        if (cheio) m_pend = 1;
    endtask

    task automatic ciclo(input logic [NDIG-1:0] an, input logic [6:0] seg, input bit rst);
        logic [5*NDIG-1:0] esp_dig, sh_obs, sh_esp;
        anodos = an; segmentos = seg; reset = rst;
        @(posedge clock);
        if (rst) modelo_reset();
        else begin
            modelo_borda(p_an, p_seg);
            p_an = an; p_seg = seg;
        end
        #1;
        for (int i = 0; i < NDIG; i++) begin
            esp_dig[5*i +: 5] = 5'(m_dig[i]);
            sh_esp[5*i +: 5]  = 5'(m_sh[i]);
            sh_obs[5*i +: 5]  = dut.shadow[i];
        end
        if (valido === 1'b1) npulsos++;
        confere("valido", valido, m_val);
        confere("erro", erro, m_erro);
        confere("digitos", digitos, esp_dig);
        confere("shadow", sh_obs, sh_esp);
`ifdef SEG7_LEITOR_CONTERRO_EN
        confere("nerros", nerros, m_nerr);
`endif
    endtask

    task automatic posicao(input int p, input int d, input int n);
        logic [NDIG-1:0] a;
        a = ~(NDIG'(1) << p);
        repeat (n) ciclo(a, tab[d], 0);
    endtask

    initial begin
        logic [NDIG-1:0] a;
        logic [6:0]      s;
        logic [5*NDIG-1:0] todos31, quadro;
        int sel, hold;
        bit rst;

        todos31 = {NDIG{5'd31}};
        modelo_reset();
        repeat (2) ciclo('1, '1, 1);
        confere("rst_digitos", digitos, todos31);
        confere("rst_valido", valido, 0);
        confere("rst_erro", erro, 0);
        ciclo('1, '1, 0);

        // two positions active at once never qualify
        repeat (10) ciclo(4'b1100, tab[8], 0);
        confere("dois_anodos", npulsos, 0);

        // single position captured, frame still incomplete
        repeat (5) ciclo(4'b1110, tab[2], 0);
        ciclo('1, '1, 0);
        confere("slot0_dois", dut.shadow[0], 2);
        confere("slot0_sem_valido", npulsos, 0);

        // full frame, slot 0 recaptured
        posicao(0, 1, 6); posicao(1, 2, 6); posicao(2, 3, 6); posicao(3, 4, 6);
        repeat (3) ciclo('1, '1, 0);
        quadro = {5'd4, 5'd3, 5'd2, 5'd1};
        confere("quadro_pulsos", npulsos, 1);
        confere("quadro_digitos", digitos, quadro);

        // unstable segments never capture
        npulsos = 0;
        repeat (6) begin
            ciclo(4'b1011, tab[8], 0);
            ciclo(4'b1011, tab[9], 0);
        end
        ciclo('1, '1, 0);
        confere("instavel_pulsos", npulsos, 0);

        // unknown pattern
        repeat (6) ciclo(4'b0111, 7'b1010101, 0);
        ciclo('1, '1, 0);
        confere("inval_erro", erro, 1);
        confere("inval_slot3", dut.shadow[3], 30);
`ifdef SEG7_LEITOR_CONTERRO_EN
        confere("inval_nerros", nerros, 1);
`endif

        // reset mid-frame discards it
        ciclo('1, '1, 1);
        npulsos = 0;
        posicao(0, 5, 6); posicao(1, 6, 6); posicao(2, 7, 6);
        ciclo('1, '1, 1);
        repeat (3) ciclo('1, '1, 0);
        confere("rst_meio_pulsos", npulsos, 0);
        confere("rst_meio_digitos", digitos, todos31);
        posicao(0, 5, 6); posicao(1, 6, 6); posicao(2, 7, 6); posicao(3, 8, 6);
        repeat (3) ciclo('1, '1, 0);
        quadro = {5'd8, 5'd7, 5'd6, 5'd5};
        confere("pos_rst_pulsos", npulsos, 1);
        confere("pos_rst_digitos", digitos, quadro);

        repeat (300) begin
            if ($urandom_range(0, 9) == 0) a = NDIG'($urandom_range(0, (1 << NDIG) - 1));
            else a = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
            sel = $urandom_range(0, 11);
            if (sel < 10)       s = tab[sel];
            else if (sel == 10) s = 7'b0111111;
            else                s = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 8);
            rst  = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 5) == 0) s = tab[$urandom_range(0, 9)];
                ciclo(a, s, 0);
            end
            if (rst) ciclo(a, s, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfalha);
        $finish;
    end

endmodule

// File: doc/seg7_leitor.md
SEG7_LEITOR -- requirements
Module: seg7_leitor

Interface
REQ-001 The module SHALL expose parameter ESTAVEL, default 4, giving the consecutive identical samples required before a digit is accepted (legal range 2..15).
REQ-002 The module SHALL expose parameter NDIG, default 4, giving the number of multiplexed display positions.
REQ-003 Port clock, input, 1 bit: single clock; all state SHALL change only on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port segmentos, input, 7 bits: active-low segment bus, bit 6 = g through bit 0 = a.
REQ-006 Port anodos, input, NDIG bits: active-low digit-select bus; exactly one bit low means that position is being driven.
REQ-007 Port digitos, output, 5*NDIG bits: decoded frame; position k occupies bits 5k+4..5k.
REQ-008 Port valido, output, 1 bit: one-cycle pulse when digitos has been updated with a complete frame.
REQ-009 Port erro, output, 1 bit: sticky flag set when an unrecognised pattern is accepted.

Function
REQ-010 Decode SHALL map 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 0111111 (dash)->5'd31; any other pattern SHALL map to 5'd30.
REQ-011 Samples SHALL be registered once (one input flop stage) before any comparison.
REQ-012 FSM states SHALL be OCIOSO, FILTRANDO and CAPTURADO.
REQ-013 OCIOSO: on a one-hot registered anodos, load the sample into the compare register, set the stability count to 1 and go to FILTRANDO.
REQ-014 FILTRANDO: if anodos and segmentos match the compare register, increment the count; otherwise reload the register with the new sample and set the count to 1, or go to OCIOSO if anodos is not one-hot.
REQ-015 When the count reaches ESTAVEL, the decoded code SHALL be written to the shadow slot for that position, the position's mask bit SHALL be set, and the FSM SHALL go to CAPTURADO.
REQ-016 CAPTURADO: remain while anodos is unchanged; on any anodos change, go to OCIOSO, or directly to FILTRANDO with count 1 if the new value is one-hot.
REQ-017 Recapturing a position whose mask bit is already set SHALL overwrite its shadow slot.
REQ-018 When all NDIG mask bits are set, on the cycle after the last capture, the shadow SHALL be copied to digitos, valido SHALL pulse high for exactly one cycle, and the mask SHALL clear.
REQ-019 Capture-to-valido latency SHALL be 1 cycle; first sample-to-capture latency SHALL be ESTAVEL+1 cycles.
REQ-020 A capture and a frame commit in the same cycle SHALL place the new capture in the next frame's shadow and mask.
REQ-021 Accepting a 5'd30 code SHALL set erro; erro SHALL clear only on reset.

Reset
REQ-022 Reset SHALL force FSM=OCIOSO, count=0, mask=0, shadow=all 5'd31, digitos=all 5'd31, valido=0, erro=0.
REQ-023 Reset asserted mid-filter or mid-frame SHALL discard the partial frame with no valido pulse.

Configuration
REQ-024 Macro SEG7_LEITOR_CONTERRO_EN, when defined, SHALL add output nerros (8 bits, reset 0), incremented on every accepted 5'd30 code and saturating at 255.
REQ-025 When SEG7_LEITOR_CONTERRO_EN is undefined, nerros SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package seg7_pkg SHALL hold the ten digit pattern constants, the dash pattern, the codes COD_TRACO=5'd31 and COD_INVAL=5'd30, and the FSM state typedef.
REQ-027 The pattern-to-code lookup SHALL be the combinational sub-module seg7_decod (7-bit in, 5-bit out).

Verification
REQ-028 anodos=1110 with segmentos=0100100 held for 5 cycles -> slot 0 captured as 2; no valido yet.
REQ-029 Positions 0..3 held for 6 cycles each with digits 1,2,3,4 -> a single valido pulse; digitos=20'h...=codes {4,3,2,1}.
REQ-030 segmentos alternating 0000000/0011000 every cycle -> no capture and no valido.
REQ-031 Pattern 1010101 held on one position -> code 30 in shadow and erro=1; with the macro defined, nerros=1.
REQ-032 Reset pulsed after 3 of 4 positions are captured -> no valido, digitos all 31; the next full frame commits normally.
REQ-033 anodos=1100 held for 10 cycles -> no capture, FSM stays OCIOSO.
